// File: rtl/image_mem_pkg.sv
// Shared constants and types for the image memory arbiter and the filter controller.
// The address-range check is enabled by defining ARB_ADDR_CHECK_EN.
package image_mem_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int REQ_LOAD  = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_WRITE = 2;

  // Input image is padded by one pixel on every side for the 3x3 window.
  localparam int IMG_DIM     = 512;
  localparam int WIN_DIM     = 3;
  localparam int PAD_DIM     = IMG_DIM + WIN_DIM - 1;
  localparam int RESULT_BASE = PAD_DIM * PAD_DIM;
  localparam int MEM_WORDS   = 2 * RESULT_BASE;

  function automatic logic [31:0] pad_addr(input int unsigned row, input int unsigned col);
    return 32'(row * PAD_DIM + col);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational cyclic-priority picker: searches req_i starting one past ptr_i
// and returns a one-hot grant (all zero when nothing requests).
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0] hi_req;
  logic [N-1:0] src;

  always_comb begin
    hi_req = '0;
    for (int i = 0; i < N; i++) begin
      hi_req[i] = req_i[i] && (i > int'(ptr_i));
    end
    // Requesters above the pointer win first; otherwise wrap to the bottom.
    src   = (|hi_req) ? hi_req : req_i;
    gnt_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between loader, window fetch
// and result writer, with bounded locking. Define ARB_ADDR_CHECK_EN for range checking.
module image_mem_arbiter
  import image_mem_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 24,
  parameter int MEM_DEPTH    = MEM_WORDS,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_MAX     = 9
) (
  input  logic                        Control_CLK,
  input  logic                        Control_RST,
  input  logic [N_REQ-1:0]            arb_req,
  input  logic [N_REQ-1:0]            arb_lock,
  input  logic [N_REQ-1:0]            arb_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] arb_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] arb_wdata,
  output logic [N_REQ-1:0]            arb_gnt,
  output logic [N_REQ-1:0]            arb_rvalid,
  output logic [DATA_WIDTH-1:0]       arb_rdata,
  output logic                        arb_busy,
  output logic                        arb_err,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output arb_state_e                  dbg_state
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  // Handshake: arb_req[i] is held until arb_gnt[i]; a grant seen before a rising
  // edge means the slot-i access is accepted at that edge, and the requester may
  // present new addr/data in the following cycle.

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d, cnt_inc;
  logic [PTR_W-1:0] rr_ptr_q;

  logic [N_REQ-1:0]      pick_gnt;
  logic [N_REQ-1:0]      owner_hot;
  logic                  owner_req, owner_lock;
  logic                  accept, addr_bad;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  sel_we, sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  mem_en_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [READ_LATENCY:0][N_REQ-1:0] rv_pipe_q;
  logic [READ_LATENCY:0]            bad_pipe_q;
  logic [N_REQ-1:0]                 rv_new;
  logic                             bad_new;

  rr_picker #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_picker (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt)
  );

  always_comb begin
    owner_hot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PTR_W'(i) == owner_q) owner_hot[i] = 1'b1;
    end
    owner_req  = |(arb_req & owner_hot);
    owner_lock = |(arb_lock & owner_hot);
  end

  always_comb begin
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        gnt_idx   = PTR_W'(i);
        sel_we    = arb_we[i];
        sel_lock  = arb_lock[i];
        sel_addr  = arb_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = arb_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept = |arb_gnt;

`ifdef ARB_ADDR_CHECK_EN
  logic err_q;

  // Out-of-range accesses are still granted so the requester never stalls.
  assign addr_bad = accept && (sel_addr >= ADDR_WIDTH'(MEM_DEPTH));

  always_ff @(posedge Control_CLK or posedge Control_RST) begin
    if (Control_RST) err_q <= 1'b0;
    else             err_q <= addr_bad;
  end

  assign arb_err = err_q;
`else
  assign addr_bad = 1'b0;
  assign arb_err  = 1'b0;
`endif

  // FSM: state register.
  always_ff @(posedge Control_CLK or posedge Control_RST) begin
    if (Control_RST) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = lock_cnt_q + CNT_W'(1);
    case (state_q)
      ARB_IDLE: begin
        if (accept && sel_lock) begin
          state_d    = ARB_LOCKED;
          owner_d    = gnt_idx;
          lock_cnt_d = CNT_W'(1);
        end
      end
      ARB_LOCKED: begin
        if (!owner_req || !owner_lock || (cnt_inc >= CNT_W'(LOCK_MAX))) begin
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // FSM: outputs. While locked only the owner can be granted.
  always_comb begin
    arb_gnt = '0;
    if (state_q == ARB_IDLE) arb_gnt = pick_gnt;
    else if (owner_req)      arb_gnt = owner_hot;
    arb_busy  = (state_q == ARB_LOCKED);
    dbg_state = state_q;
  end

  assign rv_new  = (accept && !sel_we) ? arb_gnt : '0;
  assign bad_new = addr_bad && !sel_we;

  always_ff @(posedge Control_CLK or posedge Control_RST) begin
    if (Control_RST) begin
      rr_ptr_q    <= PTR_W'(N_REQ - 1);
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rv_pipe_q   <= '0;
      bad_pipe_q  <= '0;
    end else begin
      mem_en_q <= accept && !addr_bad;
      mem_we_q <= accept && !addr_bad && sel_we;
      if (accept) begin
        rr_ptr_q    <= gnt_idx;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      // Stage 0 lines up with mem_en; the last stage lines up with mem_rdata.
      rv_pipe_q  <= {rv_pipe_q[READ_LATENCY-1:0], rv_new};
      bad_pipe_q <= {bad_pipe_q[READ_LATENCY-1:0], bad_new};
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign arb_rvalid = rv_pipe_q[READ_LATENCY];
  assign arb_rdata  = ((|arb_rvalid) && !bad_pipe_q[READ_LATENCY]) ? mem_rdata : '0;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter: reset, single read, rotation, locks,
// mid-operation reset and the optional ARB_ADDR_CHECK_EN range check.
module tb_image_mem_arbiter;
  import image_mem_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 24;
  localparam int DEPTH = 528392;
`ifdef ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            Control_CLK = 1'b0;
  logic            Control_RST;
  logic [2:0]      arb_req, arb_lock, arb_we;
  logic [3*AW-1:0] arb_addr;
  logic [3*DW-1:0] arb_wdata;
  logic [2:0]      arb_gnt, arb_rvalid;
  logic [DW-1:0]   arb_rdata;
  logic            arb_busy, arb_err;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  arb_state_e      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0]    hist_rv;
  logic [DW-1:0] hist_rd;

  image_mem_arbiter dut (
    .Control_CLK (Control_CLK),
    .Control_RST (Control_RST),
    .arb_req     (arb_req),
    .arb_lock    (arb_lock),
    .arb_we      (arb_we),
    .arb_addr    (arb_addr),
    .arb_wdata   (arb_wdata),
    .arb_gnt     (arb_gnt),
    .arb_rvalid  (arb_rvalid),
    .arb_rdata   (arb_rdata),
    .arb_busy    (arb_busy),
    .arb_err     (arb_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .dbg_state   (dbg_state)
  );

  // Clock / reset block
  always #5 Control_CLK = ~Control_CLK;

  // Read-only RAM model with one cycle of latency.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'd5) return 24'h00ABCD;
    return a[DW-1:0] ^ 24'h5A5A5A;
  endfunction

  always @(posedge Control_CLK) begin
    if (mem_en && !mem_we) mem_rdata <= mem_word(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic lk, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    arb_req[i]              = r;
    arb_lock[i]             = lk;
    arb_we[i]               = w;
    arb_addr[i*AW +: AW]    = a;
    arb_wdata[i*DW +: DW]   = d;
  endtask

  // One clock: check the grant before the edge, then the memory strobe and the
  // read return from the access accepted one edge earlier.
  task automatic cyc(input logic [2:0] exp_gnt, input logic exp_busy, input string tag);
    int            g;
    logic [AW-1:0] a;
    logic          we, bad, issued;
    logic [DW-1:0] wd, acc_rd;
    logic [2:0]    acc_rv;
    #1;
    check({tag, ".gnt"}, 32'(arb_gnt), 32'(exp_gnt));
    check({tag, ".busy"}, 32'(arb_busy), 32'(exp_busy));
    check({tag, ".state"}, 32'(dbg_state), 32'(exp_busy));
    g = -1;
    for (int i = 0; i < 3; i++) if (exp_gnt[i]) g = i;
    a = '0; we = 1'b0; wd = '0;
    if (g >= 0) begin
      a  = arb_addr[g*AW +: AW];
      we = arb_we[g];
      wd = arb_wdata[g*DW +: DW];
    end
    bad    = (g >= 0) && CHK && (a >= 32'(DEPTH));
    issued = (g >= 0) && !bad;
    acc_rv = ((g >= 0) && !we) ? exp_gnt : 3'b000;
    acc_rd = bad ? '0 : mem_word(a);
    @(posedge Control_CLK);
    #1;
    check({tag, ".mem_en"}, 32'(mem_en), 32'(issued));
    check({tag, ".mem_we"}, 32'(mem_we), 32'(issued && we));
    if (issued) check({tag, ".mem_addr"}, mem_addr, a);
    if (issued && we) check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wd));
    check({tag, ".err"}, 32'(arb_err), 32'(bad));
    check({tag, ".rvalid"}, 32'(arb_rvalid), 32'(hist_rv));
    if (hist_rv != 3'b000) check({tag, ".rdata"}, 32'(arb_rdata), 32'(hist_rd));
    hist_rv = acc_rv;
    hist_rd = acc_rd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt"}, 32'(arb_gnt), 0);
    check({tag, ".rvalid"}, 32'(arb_rvalid), 0);
    check({tag, ".rdata"}, 32'(arb_rdata), 0);
    check({tag, ".busy"}, 32'(arb_busy), 0);
    check({tag, ".err"}, 32'(arb_err), 0);
    check({tag, ".mem_en"}, 32'(mem_en), 0);
    check({tag, ".mem_we"}, 32'(mem_we), 0);
    check({tag, ".mem_addr"}, mem_addr, 0);
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  initial begin
    logic [2:0] rot [6];
    Control_RST = 1'b1;
    arb_req = '0; arb_lock = '0; arb_we = '0; arb_addr = '0; arb_wdata = '0;
    hist_rv = '0; hist_rd = '0;
    repeat (2) @(posedge Control_CLK);
    #1;
    check_all_zero("reset");
    Control_RST = 1'b0;

    // Single read by the window fetcher.
    set_req(1, 1'b1, 1'b0, 1'b0, 32'd5, 24'h0);
    cyc(3'b010, 1'b0, "t1_acc");
    arb_req = '0;
    cyc(3'b000, 1'b0, "t1_mem");
    cyc(3'b000, 1'b0, "t1_idle");

    // Full contention, no locks; pointer sits at 1 after the first test.
    set_req(0, 1'b1, 1'b0, 1'b0, 32'd100, 24'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'd200, 24'h0);
    set_req(2, 1'b1, 1'b0, 1'b1, 32'd300, 24'h123456);
    rot[0] = 3'b100; rot[1] = 3'b001; rot[2] = 3'b010;
    rot[3] = 3'b100; rot[4] = 3'b001; rot[5] = 3'b010;
    for (int k = 0; k < 6; k++) cyc(rot[k], 1'b0, $sformatf("t2_rr%0d", k));

    arb_req = 3'b001;
    cyc(3'b001, 1'b0, "t3_pre");

    // 9-read window with the lock dropped on the last fetch.
    arb_req = 3'b111;
    for (int k = 0; k < 9; k++) begin
      arb_lock = (k < 8) ? 3'b010 : 3'b000;
      arb_addr[1*AW +: AW] = 32'(1000 + k);
      cyc(3'b010, k > 0, $sformatf("t3_lock%0d", k));
    end
    arb_lock = '0;
    cyc(3'b100, 1'b0, "t3_next");
    cyc(3'b001, 1'b0, "t3_pre2");

    // Lock stuck high: forced release after LOCK_MAX grants.
    arb_lock = 3'b010;
    for (int k = 0; k < 9; k++) cyc(3'b010, k > 0, $sformatf("t4_lock%0d", k));
    cyc(3'b100, 1'b0, "t4_rel");
    cyc(3'b001, 1'b0, "t4_r0");
    cyc(3'b010, 1'b0, "t4_relock");
    arb_req = '0; arb_lock = '0;
    cyc(3'b000, 1'b1, "t4_drop");
    cyc(3'b000, 1'b0, "t4_idle");

    // Reset one cycle after a read accept.
    arb_req = 3'b010;
    arb_addr[1*AW +: AW] = 32'd7;
    cyc(3'b010, 1'b0, "t5_acc");
    arb_req = '0;
    Control_RST = 1'b1;
    #1;
    check_all_zero("t5_rst");
    @(posedge Control_CLK);
    #1;
    check("t5_rst.rvalid1", 32'(arb_rvalid), 0);
    @(posedge Control_CLK);
    #1;
    check("t5_rst.rvalid2", 32'(arb_rvalid), 0);
    Control_RST = 1'b0;
    hist_rv = '0;
    arb_req = 3'b111;
    cyc(3'b001, 1'b0, "t5_first");
    cyc(3'b010, 1'b0, "t5_second");
    arb_req = '0;
    cyc(3'b000, 1'b0, "t5_drain");
    cyc(3'b000, 1'b0, "t5_drain2");

    // Address at the memory depth: write, then read.
    set_req(2, 1'b1, 1'b0, 1'b1, 32'(DEPTH), 24'hFEDCBA);
    arb_req = 3'b100;
    cyc(3'b100, 1'b0, "t6_wr");
    set_req(2, 1'b0, 1'b0, 1'b0, 32'd0, 24'h0);
    set_req(0, 1'b1, 1'b0, 1'b0, 32'(DEPTH), 24'h0);
    arb_req = 3'b001;
    cyc(3'b001, 1'b0, "t6_rd");
    arb_req = '0;
    cyc(3'b000, 1'b0, "t6_rv");
    cyc(3'b000, 1'b0, "t6_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
